// File: rtl/mdr_pkg.sv
// Shared widths, route encoding and route decode for the MDR result demux.
package mdr_pkg;

    // MSB index of the double-width result word.
    localparam int unsigned DW_DBL = 63;

    typedef enum logic [1:0] {
        RT_A = 2'b00,
        RT_B = 2'b01,
        RT_C = 2'b10
    } route_e;

    // One-hot channel enable {C, B, A}; sel[1] wins, so 2'b11 also routes to C.
    function automatic logic [2:0] route_dec(input logic [1:0] sel);
        logic [2:0] en;
        if (sel[1]) begin
            en = 3'b100;
        end else if (sel[0]) begin
            en = 3'b010;
        end else begin
            en = 3'b001;
        end
        return en;
    endfunction

endpackage

// File: rtl/mdr_out_slot.sv
// Two-entry output FIFO for one demux channel. The head stays stable while not popped,
// and when empty the output keeps the last word that was popped.
module mdr_out_slot
    import mdr_pkg::*;
#(
    parameter int unsigned DW    = DW_DBL + 1,
    parameter int unsigned Depth = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o
);

    localparam logic [1:0] FullCnt = 2'(Depth);

    logic [1:0][DW-1:0] mem_q, mem_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [DW-1:0]      last_q, last_d;
    logic               do_push, do_pop;

    // Status and head word, all from registered state.
    always_comb begin
        full_o  = (cnt_q == FullCnt);
        empty_o = (cnt_q == 2'd0);
        head_o  = empty_o ? last_q : mem_q[rd_ptr_q];
    end

    // Next-state: pop ignored when empty, push allowed into a full FIFO only with a pop.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        last_d   = do_pop ? mem_q[rd_ptr_q] : last_q;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/mdr_result_demux.sv
// Registered 1-to-3 result demultiplexer: steers each accepted word into channel A, B or C,
// each buffered by its own two-entry FIFO.
module mdr_result_demux
    import mdr_pkg::*;
#(
    parameter int unsigned CH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sel,
    input  logic [DW_DBL:0] in_data,
    output logic            a_valid,
    input  logic            a_ready,
    output logic [DW_DBL:0] a_data,
    output logic            b_valid,
    input  logic            b_ready,
    output logic [DW_DBL:0] b_data,
    output logic            c_valid,
    input  logic            c_ready,
    output logic [DW_DBL:0] c_data,
    output logic            busy
);

    logic [2:0] ch_en;
    logic [2:0] ch_full;
    logic [2:0] ch_empty;
    logic [2:0] ch_pop;
    logic [2:0] ch_push;

    // Decode route, gate acceptance on the targeted channel, derive pops and busy.
    always_comb begin
        ch_en    = route_dec(in_sel);
        ch_pop   = {c_ready, b_ready, a_ready} & ~ch_empty;
        // A full channel can still accept when its consumer frees a slot this cycle.
        in_ready = |(ch_en & (~ch_full | ch_pop));
        ch_push  = ch_en & {3{in_valid & in_ready}};
        a_valid  = ~ch_empty[0];
        b_valid  = ~ch_empty[1];
        c_valid  = ~ch_empty[2];
        busy     = ~&ch_empty;
    end

    mdr_out_slot #(
        .DW    (DW_DBL + 1),
        .Depth (CH_DEPTH)
    ) u_slot_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ch_push[0]),
        .data_i  (in_data),
        .pop_i   (ch_pop[0]),
        .full_o  (ch_full[0]),
        .empty_o (ch_empty[0]),
        .head_o  (a_data)
    );

    mdr_out_slot #(
        .DW    (DW_DBL + 1),
        .Depth (CH_DEPTH)
    ) u_slot_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ch_push[1]),
        .data_i  (in_data),
        .pop_i   (ch_pop[1]),
        .full_o  (ch_full[1]),
        .empty_o (ch_empty[1]),
        .head_o  (b_data)
    );

    mdr_out_slot #(
        .DW    (DW_DBL + 1),
        .Depth (CH_DEPTH)
    ) u_slot_c (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ch_push[2]),
        .data_i  (in_data),
        .pop_i   (ch_pop[2]),
        .full_o  (ch_full[2]),
        .empty_o (ch_empty[2]),
        .head_o  (c_data)
    );

endmodule

// File: tb/tb_mdr_result_demux.sv
// Directed and randomised bench for mdr_result_demux. Inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_mdr_result_demux;
    import mdr_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sel;
    logic [DW_DBL:0] in_data;
    logic            a_valid, a_ready;
    logic [DW_DBL:0] a_data;
    logic            b_valid, b_ready;
    logic [DW_DBL:0] b_data;
    logic            c_valid, c_ready;
    logic [DW_DBL:0] c_data;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdr_result_demux dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .c_data   (c_data),
        .busy     (busy)
    );

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 2'b00;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        c_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Drive one word at the falling edge, let it clock in, return at the next falling edge + 1.
    task automatic push_word(input logic [1:0] sel, input logic [DW_DBL:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({a_valid, b_valid, c_valid, busy, in_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00001", {a_valid, b_valid, c_valid, busy, in_ready});
        end
        checks++;
        if ({a_data, b_data, c_data} !== '0) begin
            failures++;
            $display("FAIL reset_data got a=%h b=%h c=%h want 0", a_data, b_data, c_data);
        end
        push_word(2'b00, 64'hAAAA);
        push_word(2'b00, 64'hBBBB);
        checks++;
        if (a_valid !== 1'b1 || busy !== 1'b1 || a_data !== 64'hAAAA) begin
            failures++;
            $display("FAIL reset_prefill got v=%b busy=%b d=%h want 1 1 aaaa", a_valid, busy, a_data);
        end
        // Assert reset mid-cycle; outputs must clear without a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || a_data !== '0) begin
            failures++;
            $display("FAIL reset_async got v=%b busy=%b rdy=%b d=%h want 0 0 1 0",
                     a_valid, busy, in_ready, a_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_routing();
        apply_reset();
        a_ready = 1'b1;
        b_ready = 1'b1;
        c_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 2'b00;
        in_data  = 64'h11;
        @(negedge clk);
        #1;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 64'h11) begin
            failures++;
            $display("FAIL route_a got v=%b d=%h want 1 11", a_valid, a_data);
        end
        in_sel  = 2'b01;
        in_data = 64'h22;
        @(negedge clk);
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_data !== 64'h22 || a_valid !== 1'b0 || a_data !== 64'h11) begin
            failures++;
            $display("FAIL route_b got bv=%b bd=%h av=%b ad=%h want 1 22 0 11",
                     b_valid, b_data, a_valid, a_data);
        end
        in_sel  = 2'b10;
        in_data = 64'h33;
        @(negedge clk);
        #1;
        checks++;
        if (c_valid !== 1'b1 || c_data !== 64'h33 || b_valid !== 1'b0) begin
            failures++;
            $display("FAIL route_c10 got cv=%b cd=%h bv=%b want 1 33 0", c_valid, c_data, b_valid);
        end
        in_sel  = 2'b11;
        in_data = 64'h44;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (c_valid !== 1'b1 || c_data !== 64'h44 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
            failures++;
            $display("FAIL route_c11 got cv=%b cd=%h av=%b bv=%b want 1 44 0 0",
                     c_valid, c_data, a_valid, b_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (c_valid !== 1'b0 || busy !== 1'b0 || c_data !== 64'h44) begin
            failures++;
            $display("FAIL route_drain got cv=%b busy=%b cd=%h want 0 0 44", c_valid, busy, c_data);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        push_word(2'b00, 64'h1);
        push_word(2'b00, 64'h2);
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 2'b00;
        in_data  = 64'h3;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_a got in_ready=%b want 0", in_ready);
        end
        in_sel  = 2'b01;
        in_data = 64'h55;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_other_ch got in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_data !== 64'h55 || a_data !== 64'h1 || a_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_result got bv=%b bd=%h av=%b ad=%h want 1 55 1 1",
                     b_valid, b_data, a_valid, a_data);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        push_word(2'b00, 64'h1);
        push_word(2'b00, 64'h2);
        @(negedge clk);
        a_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'b00;
        in_data  = 64'h3;
        #1;
        checks++;
        if (in_ready !== 1'b1 || a_data !== 64'h1) begin
            failures++;
            $display("FAIL fpp_accept got rdy=%b ad=%h want 1 1", in_ready, a_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 64'h2) begin
            failures++;
            $display("FAIL fpp_second got v=%b d=%h want 1 2", a_valid, a_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 64'h3) begin
            failures++;
            $display("FAIL fpp_third got v=%b d=%h want 1 3", a_valid, a_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fpp_empty got v=%b busy=%b want 0 0", a_valid, busy);
        end
    endtask

    task automatic test_stability();
        apply_reset();
        push_word(2'b10, 64'h77);
        push_word(2'b11, 64'h88);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (c_valid !== 1'b1 || c_data !== 64'h77) begin
                failures++;
                $display("FAIL stable_hold[%0d] got v=%b d=%h want 1 77", i, c_valid, c_data);
            end
        end
        c_ready = 1'b1;
        @(negedge clk);
        c_ready = 1'b0;
        #1;
        checks++;
        if (c_valid !== 1'b1 || c_data !== 64'h88) begin
            failures++;
            $display("FAIL stable_next got v=%b d=%h want 1 88", c_valid, c_data);
        end
    endtask

    task automatic test_random();
        logic [DW_DBL:0] qa[$];
        logic [DW_DBL:0] qb[$];
        logic [DW_DBL:0] qc[$];
        logic [2:0]      en;
        logic            exp_rdy;
        int              cnt;
        int              shown = 0;
        int              fail0;
        apply_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = {$urandom, $urandom};
            a_ready  = ($urandom_range(0, 2) == 0);
            b_ready  = ($urandom_range(0, 2) == 0);
            c_ready  = ($urandom_range(0, 1) == 0);
            #1;
            fail0 = failures;
            checks++;
            if (a_valid !== (qa.size() > 0) || (qa.size() > 0 && a_data !== qa[0])) begin
                failures++;
                if (shown < 10) $display("FAIL rnd_a cyc=%0d got v=%b d=%h want v=%0d d=%h",
                                         cyc, a_valid, a_data, qa.size() > 0,
                                         qa.size() > 0 ? qa[0] : '0);
            end
            checks++;
            if (b_valid !== (qb.size() > 0) || (qb.size() > 0 && b_data !== qb[0])) begin
                failures++;
                if (shown < 10) $display("FAIL rnd_b cyc=%0d got v=%b d=%h want v=%0d d=%h",
                                         cyc, b_valid, b_data, qb.size() > 0,
                                         qb.size() > 0 ? qb[0] : '0);
            end
            checks++;
            if (c_valid !== (qc.size() > 0) || (qc.size() > 0 && c_data !== qc[0])) begin
                failures++;
                if (shown < 10) $display("FAIL rnd_c cyc=%0d got v=%b d=%h want v=%0d d=%h",
                                         cyc, c_valid, c_data, qc.size() > 0,
                                         qc.size() > 0 ? qc[0] : '0);
            end
            checks++;
            if (busy !== (qa.size() + qb.size() + qc.size() > 0)) begin
                failures++;
                if (shown < 10) $display("FAIL rnd_busy cyc=%0d got %b want %0d",
                                         cyc, busy, qa.size() + qb.size() + qc.size() > 0);
            end
            en = in_sel[1] ? 3'b100 : (in_sel[0] ? 3'b010 : 3'b001);
            if (en[0]) begin
                cnt = qa.size();
                exp_rdy = (cnt < 2) || a_ready;
            end else if (en[1]) begin
                cnt = qb.size();
                exp_rdy = (cnt < 2) || b_ready;
            end else begin
                cnt = qc.size();
                exp_rdy = (cnt < 2) || c_ready;
            end
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                if (shown < 10) $display("FAIL rnd_in_ready cyc=%0d sel=%b got %b want %b",
                                         cyc, in_sel, in_ready, exp_rdy);
            end
            if (failures != fail0) shown++;
            if (a_ready && qa.size() > 0) void'(qa.pop_front());
            if (b_ready && qb.size() > 0) void'(qb.pop_front());
            if (c_ready && qc.size() > 0) void'(qc.pop_front());
            if (in_valid && exp_rdy) begin
                if (en[0]) qa.push_back(in_data);
                else if (en[1]) qb.push_back(in_data);
                else qc.push_back(in_data);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_full_push_pop();
        test_stability();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
